// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: a Moore FSM that steps each instruction through
// fetch/decode/execute/memory/writeback and drives the shared-memory, shared-ALU datapath.
module multicycle_control_unit #(
    parameter int unsigned MEM_WAIT      = 0,
    parameter bit          ENABLE_BRANCH = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic        PCWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [5:0]  ALUOp,
    output logic [1:0]  PCSrc,
    output logic        Branch,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_ADDI_EX = 4'd8,
        S_ADDI_WB = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [5:0] opcode, funct;
    logic       wait_done, in_mem_state, funct_ok, decode_legal;
    state_e     decode_target;
    logic       unused_instr_bits;

    assign opcode            = instruction[31:26];
    assign funct             = instruction[5:0];
    assign unused_instr_bits = ^instruction[25:6];

    // A memory state is left on the cycle its wait counter reaches MEM_WAIT.
    assign wait_done    = (wait_q == WAIT_LAST);
    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    always_comb begin
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR: funct_ok = 1'b1;
            default:                                       funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        decode_target = S_FETCH;
        decode_legal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                if (funct_ok) decode_target = S_EXEC;
                else          decode_legal  = 1'b0;
            end
            OP_LW, OP_SW: decode_target = S_MEMADR;
            OP_ADDI:      decode_target = S_ADDI_EX;
            OP_BEQ: begin
                if (ENABLE_BRANCH) decode_target = S_BRANCH;
                else               decode_legal  = 1'b0;
            end
            OP_J: begin
                if (ENABLE_BRANCH) decode_target = S_JUMP;
                else               decode_legal  = 1'b0;
            end
            default: decode_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = wait_done ? S_DECODE : S_FETCH;
            S_DECODE:  state_d = decode_target;
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = wait_done ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = wait_done ? S_FETCH : S_MEMWR;
            S_EXEC:    state_d = S_ALUWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            // Writeback, branch, jump and the unused encodings 12..15 all return to FETCH.
            default:   state_d = S_FETCH;
        endcase
        wait_d = (in_mem_state && !wait_done) ? wait_q + 4'd1 : 4'd0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // NOTE: every output is given a default before the case, so no latch can be inferred.
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = FN_ADD;
        PCSrc    = 2'b00;
        Branch   = 1'b0;
        illegal  = 1'b0;
        // While reset is high the defaults stand, so an abandoned instruction cannot write.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = wait_done;
                    PCWrite = wait_done;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    illegal = !decode_legal;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = funct;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDI_WB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = FN_SUB;
                    Branch  = 1'b1;
                    PCSrc   = 2'b01;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle control unit for the MIPS core. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the shared-memory/shared-ALU datapath strobes, supports configurable memory wait states, and optionally supports BEQ/J. It sits beside the datapath, reading the instruction register output and driving all datapath mux selects and enables.

Parameters:
MEM_WAIT, 0, extra cycles held in each memory-access state (FETCH, MEMRD, MEMWR); range 0..15
ENABLE_BRANCH, 1, 1 = BEQ (000100) and J (000010) decoded; 0 = both treated as illegal

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
instruction  input  32  IR contents; stable from the final FETCH cycle until FETCH is re-entered
PCWrite  output  1  PC load enable
IorD  output  1  memory address select, 0=PC, 1=ALUOut
IRWrite  output  1  IR load enable
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
MemToReg  output  1  writeback select, 1=MDR
RegDst  output  1  destination select, 1=rd, 0=rt
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=A register
ALUSrcB  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  output  6  ALU function in funct encoding; ADD=100000, SUB=100010, AND=100100, OR=100101, XOR=100110, NOR=100111
PCSrc  output  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
Branch  output  1  PC load qualified by the ALU zero flag
illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode or funct
state  output  4  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset effect: state <= FETCH and wait counter <= 0. While reset is high, all strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Branch, illegal) are forced to 0 and ALUOp = 100000.
- Output defaults in every state: all 1-bit outputs 0, ALUSrcB=00, PCSrc=00, ALUOp=100000. Outputs are a function of the state register only, plus the wait counter where noted.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, ADDI_EX=8, ADDI_WB=9, BRANCH=10, JUMP=11.
- Memory wait states: FETCH, MEMRD and MEMWR each last MEM_WAIT+1 cycles. The 4-bit wait counter increments while in these states and clears on exit. MemRead/MemWrite are held for every cycle of the state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD. IRWrite=1 and PCWrite=1 on the final cycle only. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD. Next state by opcode:
  - 000000 with supported funct -> EXEC
  - 100011 (LW) or 101011 (SW) -> MEMADR
  - 001000 (ADDI) -> ADDI_EX
  - 000100 -> BRANCH and 000010 -> JUMP, when ENABLE_BRANCH=1
  - otherwise -> illegal=1, next state FETCH
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1 -> MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite=1, IorD=1 -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=instruction[5:0] -> ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemToReg=0 -> FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, Branch=1, PCSrc=01 -> FETCH.
- JUMP: PCWrite=1, PCSrc=10 -> FETCH.
- Cycle counts with W=MEM_WAIT: R-type 4+W, ADDI 4+W, LW 5+2W, SW 4+2W, BEQ 3+W, J 3+W.
- Reset asserted mid-instruction or mid-wait: the FSM abandons the instruction and is in FETCH with counter 0 on the next cycle. No RegWrite or MemWrite occurs in the reset cycle.
- Unreachable encodings 12..15 return to FETCH on the next cycle with all strobes 0.

Test Plan:
- MEM_WAIT=0, reset 2 cycles, then ADD 0x012A4020 -> states 0,1,6,7,0. EXEC ALUOp=100000; ALUWB RegWrite=1, RegDst=1; IRWrite/PCWrite high only in FETCH.
- MEM_WAIT=0, LW 0x8FA80008 -> states 0,1,2,3,4. MEMRD MemRead=1, IorD=1; MEMWB RegWrite=1, MemToReg=1, RegDst=0; 5 cycles total.
- MEM_WAIT=2, SW 0xAFA9000C -> FETCH held 3 cycles with IRWrite only on the 3rd; MEMWR MemWrite=1 for exactly 3 cycles; RegWrite never 1; 8 cycles total.
- NOR 0x01F07027 then XOR 0x018D5826 -> EXEC ALUOp=100111, then 100110; ADDI 0x21280064 -> ADDI_EX ALUSrcB=10, ADDI_WB RegWrite=1, RegDst=0.
- ENABLE_BRANCH=1: BEQ 0x11090003 -> BRANCH with Branch=1, ALUOp=100010, PCSrc=01. J 0x08000010 -> PCWrite=1, PCSrc=10. With ENABLE_BRANCH=0 the same BEQ gives an illegal pulse in DECODE, then FETCH.
- MEM_WAIT=1: assert reset during the 2nd MEMRD cycle of an LW -> next cycle state=0, no RegWrite pulse; funct 000000 with opcode 0 -> illegal=1 for exactly one cycle.
